// File: rtl/mdu_hilo_if.sv
// Issue-side bundle between the decode/issue logic and the HI/LO multiply/divide unit.
interface mdu_hilo_if #(
    parameter int W = 32
);
    logic         start;
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         flush;
    logic         busy;
    logic         done;
    logic         div_zero;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    modport master (
        output start, op, a, b, flush,
        input  busy, done, div_zero, hi, lo
    );

    modport slave (
        input  start, op, a, b, flush,
        output busy, done, div_zero, hi, lo
    );
endinterface

// File: rtl/mdu_hilo.sv
// Radix-2 iterative multiply/divide unit owning the architectural HI/LO pair.
// Shift-add multiply and restoring divide on magnitudes, sign fixed up in one final cycle.
//   state  | meaning
//   IDLE   | waiting for start; MTHI/MTLO write HI/LO directly here
//   CALC   | one product/quotient bit per cycle, counter 0..W-1
//   FIX    | sign correction (or divide-by-zero result) written to HI/LO
module mdu_hilo #(
    parameter int           W       = 32,
    parameter logic [W-1:0] DIV0_LO = 32'hFFFFFFFF
) (
    input  logic      clk,
    input  logic      rst_n,
    mdu_hilo_if.slave mdu_if
);
    localparam int            CW       = $clog2(W);
    localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;

    logic [1:0]     state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [2*W-1:0] acc_q, acc_d;
    logic [W-1:0]   opd_q, opd_d;
    logic [W-1:0]   hi_q, hi_d;
    logic [W-1:0]   lo_q, lo_d;
    logic           is_div_q, is_div_d;
    logic           neg_q, neg_d;
    logic           rneg_q, rneg_d;
    logic           div0_q, div0_d;
    logic           done_q, done_d;
    logic           dz_q, dz_d;

    logic           sgn_op;
    logic           b_zero;
    logic [W-1:0]   abs_a, abs_b;
    logic [W:0]     add_sum, msum;
    logic [W:0]     rem_sh, rem_sub;
    logic [2*W-1:0] prod_fix;

    assign sgn_op   = ~mdu_if.op[0];
    assign b_zero   = (mdu_if.b == '0);
    assign abs_a    = (sgn_op && mdu_if.a[W-1]) ? -mdu_if.a : mdu_if.a;
    assign abs_b    = (sgn_op && mdu_if.b[W-1]) ? -mdu_if.b : mdu_if.b;

    // multiply: acc = {partial product, remaining multiplier bits}, shifted right each step
    assign add_sum  = {1'b0, acc_q[2*W-1:W]} + {1'b0, opd_q};
    assign msum     = acc_q[0] ? add_sum : {1'b0, acc_q[2*W-1:W]};
    // divide: acc = {partial remainder, remaining dividend/quotient bits}, shifted left
    assign rem_sh   = acc_q[2*W-1:W-1];
    assign rem_sub  = rem_sh - {1'b0, opd_q};
    assign prod_fix = neg_q ? -acc_q : acc_q;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        opd_d    = opd_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        is_div_d = is_div_q;
        neg_d    = neg_q;
        rneg_d   = rneg_q;
        div0_d   = div0_q;
        done_d   = 1'b0;
        dz_d     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (mdu_if.start && !mdu_if.flush) begin
                    case (mdu_if.op)
                        3'd0, 3'd1, 3'd2, 3'd3: begin
                            is_div_d = mdu_if.op[1];
                            neg_d    = sgn_op & (mdu_if.a[W-1] ^ mdu_if.b[W-1]);
                            rneg_d   = sgn_op & mdu_if.a[W-1];
                            div0_d   = mdu_if.op[1] & b_zero;
                            cnt_d    = '0;
                            if (mdu_if.op[1] && b_zero) begin
                                acc_d   = {{W{1'b0}}, mdu_if.a};
                                state_d = S_FIX;
                            end else if (mdu_if.op[1]) begin
                                acc_d   = {{W{1'b0}}, abs_a};
                                opd_d   = abs_b;
                                state_d = S_CALC;
                            end else begin
                                acc_d   = {{W{1'b0}}, abs_b};
                                opd_d   = abs_a;
                                state_d = S_CALC;
                            end
                        end
                        3'd4: begin
                            hi_d   = mdu_if.a;
                            done_d = 1'b1;
                        end
                        3'd5: begin
                            lo_d   = mdu_if.a;
                            done_d = 1'b1;
                        end
                        default: ;
                    endcase
                end
            end
            S_CALC: begin
                if (mdu_if.flush) begin
                    state_d = S_IDLE;
                end else begin
                    if (is_div_q) begin
                        acc_d = rem_sub[W] ? {rem_sh[W-1:0], acc_q[W-2:0], 1'b0}
                                           : {rem_sub[W-1:0], acc_q[W-2:0], 1'b1};
                    end else begin
                        acc_d = {msum, acc_q[W-1:1]};
                    end
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) state_d = S_FIX;
                end
            end
            S_FIX: begin
                state_d = S_IDLE;
                if (!mdu_if.flush) begin
                    done_d = 1'b1;
                    if (div0_q) begin
                        hi_d = acc_q[W-1:0];
                        lo_d = DIV0_LO;
                        dz_d = 1'b1;
                    end else if (is_div_q) begin
                        lo_d = neg_q  ? -acc_q[W-1:0]   : acc_q[W-1:0];
                        hi_d = rneg_q ? -acc_q[2*W-1:W] : acc_q[2*W-1:W];
                    end else begin
                        hi_d = prod_fix[2*W-1:W];
                        lo_d = prod_fix[W-1:0];
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            opd_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            is_div_q <= 1'b0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
            div0_q   <= 1'b0;
            done_q   <= 1'b0;
            dz_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            opd_q    <= opd_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            is_div_q <= is_div_d;
            neg_q    <= neg_d;
            rneg_q   <= rneg_d;
            div0_q   <= div0_d;
            done_q   <= done_d;
            dz_q     <= dz_d;
        end
    end

    assign mdu_if.busy     = (state_q != S_IDLE);
    assign mdu_if.done     = done_q;
    assign mdu_if.div_zero = dz_q;
    assign mdu_if.hi       = hi_q;
    assign mdu_if.lo       = lo_q;
endmodule

// File: tb/tb_mdu_hilo.sv
// Self-checking bench for mdu_hilo: directed corner cases plus random ops against an arithmetic model.
module tb_mdu_hilo;
    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;
    logic [31:0] mhi, mlo;

    mdu_hilo_if #(.W(32)) bus ();

    mdu_hilo #(.W(32), .DIV0_LO(32'hFFFFFFFF)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .mdu_if (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Result of an arithmetic op computed with plain 64-bit arithmetic.
    task automatic ref_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] rhi, output logic [31:0] rlo, output logic rdz);
        longint      sa, sb, sq, sr;
        logic [63:0] p, q, r;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        rdz = 1'b0;
        rhi = mhi;
        rlo = mlo;
        case (op)
            3'd0: begin p = 64'(sa * sb); rhi = p[63:32]; rlo = p[31:0]; end
            3'd1: begin p = {32'd0, a} * {32'd0, b}; rhi = p[63:32]; rlo = p[31:0]; end
            3'd2, 3'd3: begin
                if (b == 32'd0) begin
                    rhi = a; rlo = 32'hFFFFFFFF; rdz = 1'b1;
                end else if (op == 3'd2) begin
                    sq = sa / sb; sr = sa % sb;
                    q = 64'(sq); r = 64'(sr);
                    rhi = r[31:0]; rlo = q[31:0];
                end else begin
                    rhi = a % b; rlo = a / b;
                end
            end
            3'd4: rhi = a;
            3'd5: rlo = a;
            default: ;
        endcase
    endtask

    // Starts an op at the current negedge; optionally pokes an ignored MTHI at cycle inj.
    task automatic do_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input int inj);
        logic [31:0] ehi, elo;
        logic        edz;
        int          ecyc, got, busy_bad, hold_bad;
        logic        ebusy;
        ref_op(op, a, b, ehi, elo, edz);
        ecyc = (op >= 3'd4) ? 1 : (edz ? 2 : 34);
        got = -1; busy_bad = 0; hold_bad = 0;
        bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            ebusy = (op < 3'd4) && (c < ecyc);
            if (bus.busy !== ebusy) busy_bad++;
            if (c < ecyc && (bus.hi !== mhi || bus.lo !== mlo)) hold_bad++;
            if (c == 1) bus.start = 1'b0;
            if (inj > 0 && c == inj) begin
                bus.start = 1'b1; bus.op = 3'd4; bus.a = 32'h12345678;
            end
            if (inj > 0 && c == inj + 1) bus.start = 1'b0;
            if (bus.done === 1'b1) begin got = c; break; end
        end
        bus.start = 1'b0;
        check({tag, " done_cycle"}, 64'(got), 64'(ecyc));
        check({tag, " busy"}, 64'(busy_bad), 64'd0);
        check({tag, " hold"}, 64'(hold_bad), 64'd0);
        check({tag, " hi"}, {32'd0, bus.hi}, {32'd0, ehi});
        check({tag, " lo"}, {32'd0, bus.lo}, {32'd0, elo});
        check({tag, " div_zero"}, {63'd0, bus.div_zero}, {63'd0, edz});
        mhi = ehi;
        mlo = elo;
    endtask

    // Starts an op and flushes it in cycle fcyc; hi/lo must be untouched and no done must appear.
    task automatic flush_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                            input logic [31:0] b, input int fcyc);
        int busy_bad, done_cnt, hold_bad;
        busy_bad = 0; done_cnt = 0; hold_bad = 0;
        bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (bus.busy !== (c <= fcyc)) busy_bad++;
            if (bus.done !== 1'b0) done_cnt++;
            if (bus.hi !== mhi || bus.lo !== mlo) hold_bad++;
            if (c == 1) bus.start = 1'b0;
            if (c == fcyc) bus.flush = 1'b1;
            if (c == fcyc + 1) bus.flush = 1'b0;
        end
        check({tag, " busy"}, 64'(busy_bad), 64'd0);
        check({tag, " no_done"}, 64'(done_cnt), 64'd0);
        check({tag, " hold"}, 64'(hold_bad), 64'd0);
    endtask

    // A start that must have no effect (reserved op, or flush in the same cycle).
    task automatic ignored_start(input string tag, input logic [2:0] op, input logic [31:0] a,
                                 input logic fl);
        int bad;
        bad = 0;
        bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = 32'd3; bus.flush = fl;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            if (c == 1) begin bus.start = 1'b0; bus.flush = 1'b0; end
            if (bus.done !== 1'b0 || bus.busy !== 1'b0) bad++;
            if (bus.hi !== mhi || bus.lo !== mlo) bad++;
        end
        check({tag, " ignored"}, 64'(bad), 64'd0);
    endtask

    task automatic reset_mid(input string tag, input int rcyc);
        bus.start = 1'b1; bus.op = 3'd2; bus.a = 32'hF0000001; bus.b = 32'd5;
        for (int c = 1; c <= rcyc; c++) begin
            @(negedge clk);
            if (c == 1) bus.start = 1'b0;
        end
        rst_n = 1'b0;
        #1;
        check({tag, " busy"}, {63'd0, bus.busy}, 64'd0);
        check({tag, " done"}, {63'd0, bus.done}, 64'd0);
        check({tag, " hi"}, {32'd0, bus.hi}, 64'd0);
        check({tag, " lo"}, {32'd0, bus.lo}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        mhi = 32'd0;
        mlo = 32'd0;
        @(negedge clk);
    endtask

    initial begin
        logic [2:0]  rop;
        logic [31:0] ra, rb;
        int          sel;
        n_tests = 0; n_fail = 0;
        mhi = 32'd0; mlo = 32'd0;
        rst_n = 1'b0;
        bus.start = 1'b0; bus.op = 3'd0; bus.a = 32'd0; bus.b = 32'd0; bus.flush = 1'b0;
        #12;
        check("rst hi", {32'd0, bus.hi}, 64'd0);
        check("rst lo", {32'd0, bus.lo}, 64'd0);
        check("rst busy", {63'd0, bus.busy}, 64'd0);
        check("rst done", {63'd0, bus.done}, 64'd0);
        check("rst div_zero", {63'd0, bus.div_zero}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        do_op("multu_max", 3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 0);
        do_op("mult_neg", 3'd0, 32'hFFFFFFFD, 32'd7, 0);
        do_op("div_neg", 3'd2, 32'hFFFFFFF9, 32'd2, 0);
        do_op("divu", 3'd3, 32'd100, 32'd7, 0);
        do_op("div_ovf", 3'd2, 32'h80000000, 32'hFFFFFFFF, 0);
        do_op("divu_zero", 3'd3, 32'd5, 32'd0, 0);
        do_op("div_zero_s", 3'd2, 32'hFFFFFF00, 32'd0, 0);
        do_op("mthi", 3'd4, 32'hDEADBEEF, 32'd0, 0);
        do_op("mtlo", 3'd5, 32'hCAFEF00D, 32'd0, 0);
        do_op("busy_start", 3'd1, 32'h00012345, 32'h00000100, 10);
        ignored_start("reserved6", 3'd6, 32'h55555555, 1'b0);
        ignored_start("reserved7", 3'd7, 32'h55555555, 1'b0);
        ignored_start("flush_idle", 3'd4, 32'h77777777, 1'b1);
        flush_op("flush_calc", 3'd1, 32'h11111111, 32'h22222222, 20);
        flush_op("flush_fix", 3'd0, 32'h0000FFFF, 32'hFFFF0000, 33);
        flush_op("flush_div0", 3'd3, 32'h00000009, 32'd0, 1);
        reset_mid("rst_mid", 10);
        do_op("mtlo_after_rst", 3'd5, 32'd1, 32'd0, 0);

        for (int i = 0; i < 24; i++) begin
            rop = 3'($urandom_range(0, 5));
            ra  = $urandom;
            sel = $urandom_range(0, 7);
            if (sel == 0)      rb = 32'd0;
            else if (sel < 3)  rb = 32'($urandom_range(1, 20));
            else if (sel == 3) rb = -32'($urandom_range(1, 20));
            else               rb = $urandom;
            do_op($sformatf("rand%0d_op%0d", i, rop), rop, ra, rb, 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/mdu_hilo.md
Name: mdu_hilo

Overview:
- Iterative multiply/divide unit that owns the architectural HI/LO register pair.
- Sits beside the execute-stage alu, directly upstream of it: its hi/lo outputs drive the alu hi/lo inputs so MFHI/MFLO-style ALU ops read them.
- Issue logic starts an op with a one-cycle start pulse and stalls on busy.
- Radix-2, one result bit per cycle: shift-add for multiply, restoring division for divide.

Parameters:
- W, 32, operand and HI/LO width.
- DIV0_LO, 32'hFFFFFFFF, value written to lo on divide-by-zero.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only when busy=0.
- op  input  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6-7 reserved.
- a  input  W  rs operand (multiplicand / dividend / MTHI/MTLO source).
- b  input  W  rt operand (multiplier / divisor).
- flush  input  1  abort the in-flight op (exception/EPC path).
- busy  output  1  op in progress; issue must stall HI/LO readers and new ops.
- done  output  1  one-cycle pulse; hi/lo hold the new result in this cycle.
- div_zero  output  1  one-cycle pulse with done when divisor=0.
- hi  output  W  HI register (multiply high word / remainder).
- lo  output  W  LO register (multiply low word / quotient).

Behaviour:
- Reset (async, rst_n=0): hi=0, lo=0, busy=0, done=0, div_zero=0, FSM=IDLE, counter=0.
- FSM states: IDLE, CALC, FIX.
- IDLE:
  - start=1 with op 0-3: latch |a|,|b| (signed ops) or a,b (unsigned ops), plus the result sign(s); counter=0; go to CALC.
  - start=1 with op 4/5: write hi=a or lo=a at that edge; done=1 next cycle; busy stays 0.
  - start=1 with op 6/7: ignored; no done, no state change.
- CALC:
  - 32 cycles; counter 0..31; one partial-product add or trial-subtract per cycle on a 2W accumulator.
  - Leaves to FIX at the edge where counter=31.
- FIX:
  - Apply sign correction:
    - signed multiply: negate the 64-bit product if signs differ.
    - DIV: quotient negative if signs differ; remainder takes the sign of the dividend.
  - Write hi/lo at the FIX edge; return to IDLE.
- Timing, with start sampled in cycle 0:
  - busy=1 in cycles 1..33.
  - done=1 and new hi/lo visible in cycle 34.
  - busy=0 in cycle 34.
- Back-to-back ops: start may be accepted in cycle 34, in the same cycle done is high.
- start while busy=1: ignored, no queuing.
- Divide-by-zero (op 2/3, b=0):
  - No CALC; hi=a, lo=DIV0_LO written at the edge after the start cycle.
  - done=1 and div_zero=1 in cycle 2; busy=1 in cycle 1 only.
- Signed overflow, DIV with a=32'h80000000 and b=32'hFFFFFFFF: lo=32'h80000000, hi=0, no flag.
- hi/lo change only at a FIX edge, a div-zero write, or an MTHI/MTLO edge. They hold otherwise, including during CALC.
- flush=1 during busy:
  - Return to IDLE at the next edge; hi/lo unchanged; no done.
  - flush has priority over FIX completion in the same cycle.
  - flush in IDLE also blocks a same-cycle start.
- Async reset mid-operation: immediate return to the reset state; the partial result is discarded.

Test Plan:
- MULTU a=32'hFFFFFFFF, b=32'hFFFFFFFF -> cycle 34 done=1, hi=32'hFFFFFFFE, lo=32'h00000001; busy high cycles 1..33.
- MULT a=-3 (32'hFFFFFFFD), b=7 -> hi=32'hFFFFFFFF, lo=32'hFFFFFFEB.
- DIV a=-7, b=2 -> lo=32'hFFFFFFFD (-3), hi=32'hFFFFFFFF (-1).
- DIVU a=100, b=7 -> lo=14, hi=2.
- DIV a=32'h80000000, b=-1 -> lo=32'h80000000, hi=0.
- DIVU a=5, b=0 -> cycle 2 done=1, div_zero=1, hi=5, lo=32'hFFFFFFFF.
- MTHI a=32'hDEADBEEF -> hi=32'hDEADBEEF, done in cycle 1, busy never high.
- start pulse during busy -> ignored, prior result unaffected.
- MULTU started, flush in cycle 20 -> busy=0 in cycle 21, no done, hi/lo keep their prior values.
- rst_n low in cycle 10 of a DIV -> outputs zero immediately; after release, a new MTLO a=1 gives lo=1.
